frame_reader: RTL and testbench

- Scan-out stage directly downstream of frame_buf.
- Generates raster timing (hsync/vsync/de) from free-running horizontal and vertical counters.
- Issues read enables and linear read addresses to the frame buffer memory, which returns data one cycle after each read.
- Presents each returned pixel with sync/de signals aligned to it, for the display/serializer stage.

---
 rtl/frame_reader.sv | 153 +++++++++++++++
 tb/tb_frame_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// Scan-out stage behind frame_buf: raster timing, frame buffer reads and pixel presentation.
// Sync/de are registered one cycle so they line up with read data returning from memory.
module frame_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 3,
  parameter int H_ACTIVE   = 4,
  parameter int H_FP       = 1,
  parameter int H_SYNC     = 2,
  parameter int H_BP       = 1,
  parameter int V_ACTIVE   = 2,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 1,
  parameter int V_BP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_en_in,
  input  logic                  buf_rdy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start,
  output logic                  underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic            ASSERT_LVL = 1'b0;
  localparam logic [HW-1:0]   H_ACT_C    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]   H_SYNC_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]   H_SYNC_HI  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0]   H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   H_ONE      = HW'(1);
  localparam logic [VW-1:0]   V_ACT_C    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]   V_SYNC_LO  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]   V_SYNC_HI  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]   V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   V_ONE      = VW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [HW-1:0]           h_cnt_q, h_cnt_d;
  logic [VW-1:0]           v_cnt_q, v_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    de_q, de_d;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    fs_q, fs_d;
  logic                    uf_q, uf_d;
  logic                    scan_s, active_s, frame_end_s, start_s;

  // Decode of the current raster position and the start/continue condition
  always_comb begin
    scan_s      = (state_q == SCAN);
    active_s    = scan_s && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    frame_end_s = scan_s && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    start_s     = (scan_en_in == ASSERT_LVL) && buf_rdy;
  end

  // Next-state logic: FSM, raster counters, read address and delayed raster outputs
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        addr_d  = '0;
        if (start_s) state_d = SCAN;
        else         state_d = IDLE;
      end
      SCAN: begin
        if (frame_end_s) begin
          // Back-to-back frames wrap straight to (0,0) with no gap cycle
          h_cnt_d = '0;
          v_cnt_d = '0;
          addr_d  = '0;
          if (start_s) state_d = SCAN;
          else         state_d = IDLE;
        end else begin
          if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = v_cnt_q + V_ONE;
          end else begin
            h_cnt_d = h_cnt_q + H_ONE;
            v_cnt_d = v_cnt_q;
          end
          if (active_s) addr_d = addr_q + ADDR_ONE;
          else          addr_d = addr_q;
        end
      end
      default: begin
        state_d = IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
        addr_d  = '0;
      end
    endcase

    de_d    = active_s;
    hsync_d = !(scan_s && (h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI));
    vsync_d = !(scan_s && (v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI));
    fs_d    = scan_s && (h_cnt_q == '0) && (v_cnt_q == '0);
    uf_d    = uf_q || (active_s && !buf_rdy);
  end

  // State and output registers; asynchronous reset returns to an idle raster
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  // Read strobe is combinational so memory data returns alongside the registered de
  assign rd_en       = active_s ? ASSERT_LVL : ~ASSERT_LVL;
  assign rd_addr     = addr_q;
  assign pix_data    = de_q ? rd_data : '0;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: hand-computed first-frame table, directed corner sequences,
// and randomized scan control checked against a frame-position reference model.
module tb_frame_reader;

  localparam int DW  = 24;
  localparam int AW  = 3;
  localparam int HA  = 4;
  localparam int HFP = 1;
  localparam int HS  = 2;
  localparam int HBP = 1;
  localparam int VA  = 2;
  localparam int VFP = 1;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  logic          clk, reset, scan_en_in, buf_rdy;
  logic          rd_en, de, hsync, vsync, frame_start, underflow;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, pix_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame position t = v*HT + h while running
  bit            m_run, m_uf, m_de, m_hs, m_vs, m_fs;
  int            m_t;
  logic [DW-1:0] m_pix;

  typedef struct {
    int            k;
    logic          rd_en;
    int            addr;
    logic          de;
    logic [DW-1:0] pix;
    logic          hs;
    logic          vs;
    logic          fs;
  } vec_t;
  vec_t tbl [17];

  frame_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .scan_en_in(scan_en_in), .buf_rdy(buf_rdy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .pix_data(pix_data),
    .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: one-cycle read latency, junk on the bus when not reading
  always @(posedge clk) begin
    if (rd_en == 1'b0) rd_data <= mem[rd_addr];
    else               rd_data <= DW'($urandom);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_active();
    return m_run && ((m_t % HT) < HA) && ((m_t / HT) < VA);
  endfunction

  function automatic int m_addr();
    int h, v, reads;
    if (!m_run) return 0;
    h = m_t % HT;
    v = m_t / HT;
    if (v < VA) reads = v * HA + ((h < HA) ? h : HA);
    else        reads = VA * HA;
    return reads % (1 << AW);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_uf = 1'b0;
    m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_fs = 1'b0; m_pix = '0;
  endtask

  task automatic model_update();
    int h, v, a;
    bit act;
    h = m_t % HT;
    v = m_t / HT;
    act = m_active();
    a = m_addr();
    m_de  = act;
    m_pix = act ? mem[a] : '0;
    m_hs  = !(m_run && h >= HA + HFP && h < HA + HFP + HS);
    m_vs  = !(m_run && v >= VA + VFP && v < VA + VFP + VS);
    m_fs  = m_run && (m_t == 0);
    if (act && !buf_rdy) m_uf = 1'b1;
    if (!m_run) begin
      if (!scan_en_in && buf_rdy) begin m_run = 1'b1; m_t = 0; end
    end else if (m_t == FT - 1) begin
      if (scan_en_in || !buf_rdy) m_run = 1'b0;
      m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic model_check();
    check("rd_en", rd_en, m_active() ? 1'b0 : 1'b1);
    check("rd_addr", rd_addr, m_addr());
    check("de", de, m_de);
    check("hsync", hsync, m_hs);
    check("vsync", vsync, m_vs);
    check("frame_start", frame_start, m_fs);
    check("underflow", underflow, m_uf);
    check("pix_data", pix_data, m_pix);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_update();
    @(negedge clk);
    model_check();
  endtask

  task automatic apply_reset();
    scan_en_in = 1'b1;
    buf_rdy    = 1'b1;
    reset      = 1'b0;
    model_reset();
    repeat (2) step();
    reset = 1'b1;
  endtask

  // Leaves the bench at the negedge right after start edge E0 (k=0)
  task automatic start_scan();
    scan_en_in = 1'b0;
    buf_rdy    = 1'b1;
    step();
  endtask

  task automatic mid_reset(input int k_at);
    start_scan();
    repeat (k_at) step();
    #2 reset = 1'b0;
    #1;
    check("mr_de", de, 1'b0);
    check("mr_hsync", hsync, 1'b1);
    check("mr_vsync", vsync, 1'b1);
    check("mr_rd_en", rd_en, 1'b1);
    check("mr_rd_addr", rd_addr, 0);
    check("mr_frame_start", frame_start, 1'b0);
    check("mr_pix", pix_data, 0);
    model_reset();
    scan_en_in = 1'b1;
    @(negedge clk);
    model_check();
    step();
    reset = 1'b1;
    repeat (6) step();
    check("mr_idle_de", de, 1'b0);
    check("mr_idle_rd_en", rd_en, 1'b1);
  endtask

  initial begin
    int k, nreads, fs_cnt, fs_first, fs_last, cyc;
    logic [AW-1:0] prev_addr;

    //          k  rd_en addr de  pix      hs    vs    fs
    tbl[0]  = '{0,  1'b0, 0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,  1'b0, 1, 1'b1, 24'd1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{3,  1'b0, 3, 1'b1, 24'd3, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{4,  1'b1, 4, 1'b1, 24'd4, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{5,  1'b1, 4, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{6,  1'b1, 4, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{7,  1'b1, 4, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8,  1'b0, 4, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{9,  1'b0, 5, 1'b1, 24'd5, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{12, 1'b1, 0, 1'b1, 24'd8, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{16, 1'b1, 0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{25, 1'b1, 0, 1'b0, 24'd0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{32, 1'b1, 0, 1'b0, 24'd0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{33, 1'b1, 0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{38, 1'b1, 0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{40, 1'b0, 0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{41, 1'b0, 1, 1'b1, 24'd1, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 1);
    reset = 1'b0; scan_en_in = 1'b1; buf_rdy = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_rd_en", rd_en, 1'b1);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_de", de, 1'b0);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    check("rst_uf", underflow, 1'b0);
    check("rst_pix", pix_data, 0);
    apply_reset();

    // First frame plus start of the second against the hand-computed table
    start_scan();
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin step(); k++; end
      check($sformatf("tbl%0d_rd_en", tbl[i].k), rd_en, tbl[i].rd_en);
      check($sformatf("tbl%0d_rd_addr", tbl[i].k), rd_addr, tbl[i].addr);
      check($sformatf("tbl%0d_de", tbl[i].k), de, tbl[i].de);
      check($sformatf("tbl%0d_pix", tbl[i].k), pix_data, tbl[i].pix);
      check($sformatf("tbl%0d_hsync", tbl[i].k), hsync, tbl[i].hs);
      check($sformatf("tbl%0d_vsync", tbl[i].k), vsync, tbl[i].vs);
      check($sformatf("tbl%0d_fs", tbl[i].k), frame_start, tbl[i].fs);
    end

    // Continuous scan: three more frame starts, 40 cycles apart, address back at 0
    fs_cnt = 0; fs_first = 0; fs_last = 0; cyc = 0;
    prev_addr = rd_addr;
    for (int i = 0; i < 3 * FT; i++) begin
      prev_addr = rd_addr;
      step(); cyc++;
      if (frame_start) begin
        if (fs_cnt == 0) fs_first = cyc;
        fs_last = cyc;
        fs_cnt++;
        check("frame_wrap_addr", prev_addr, 0);
      end
    end
    check("fs_count", fs_cnt, 3);
    check("fs_period", fs_last - fs_first, 2 * FT);

    // Stop request at h=2, v=0: the frame still completes its reads
    step();
    scan_en_in = 1'b1;
    nreads = 0;
    for (int i = 0; i < 60; i++) begin
      if (rd_en == 1'b0) nreads++;
      step();
    end
    check("stop_reads", nreads, 6);
    check("stop_de", de, 1'b0);
    check("stop_rd_en", rd_en, 1'b1);

    // Underflow: buf_rdy dropped in an active cycle, held low through frame end
    apply_reset();
    start_scan();
    repeat (2) step();
    buf_rdy = 1'b0;
    check("uf_before", underflow, 1'b0);
    step();
    check("uf_set", underflow, 1'b1);
    repeat (45) step();
    check("uf_idle_de", de, 1'b0);
    check("uf_idle_rd_en", rd_en, 1'b1);
    buf_rdy = 1'b1;
    scan_en_in = 1'b0;
    repeat (45) step();
    check("uf_sticky", underflow, 1'b1);
    apply_reset();
    check("uf_cleared", underflow, 1'b0);

    // Asynchronous reset mid-line: once during active output, once inside both syncs
    mid_reset(9);
    mid_reset(30);

    // Randomized scan control and memory contents
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      scan_en_in = ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0;
      buf_rdy    = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
